// File: rtl/tilt_pkg.sv
// rtl/tilt_pkg.sv - class codes shared by the tilt classifier and the run-state selector
package tilt_pkg;

    typedef logic [4:0] cls_t;

    localparam cls_t CLS_NONE = 5'b00000;
    localparam cls_t CLS_B    = 5'b00001;
    localparam cls_t CLS_R    = 5'b00010;
    localparam cls_t CLS_S    = 5'b00100;
    localparam cls_t CLS_L    = 5'b01000;
    localparam cls_t CLS_F    = 5'b10000;

    // Class selected by one axis given the sign of its sample.
    function automatic cls_t axis_cls(input logic is_y, input logic neg);
        if (is_y) begin
            return neg ? CLS_B : CLS_F;
        end
        return neg ? CLS_L : CLS_R;
    endfunction

endpackage

// File: rtl/tilt_debounce.sv
// rtl/tilt_debounce.sv - commits a candidate class after DEB_COUNT consecutive repeats
module tilt_debounce
    import tilt_pkg::*;
#(
    parameter int DEB_COUNT = 4
) (
    input  logic       clk,
    input  logic       I_rst,
    input  logic       enable,
    input  logic [4:0] cand,
    input  logic       cand_valid,
    output logic [4:0] set,
    output logic       set_change
);

    localparam int CW = $clog2(DEB_COUNT + 1);
    localparam logic [CW-1:0] DEB_W = CW'(DEB_COUNT);

    cls_t          set_q, set_d;
    cls_t          last_q, last_d;
    logic          chg_q, chg_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] n_cnt;

    always_ff @(posedge clk or posedge I_rst) begin
        if (I_rst) begin
            set_q   <= CLS_NONE;
            last_q  <= CLS_NONE;
            chg_q   <= 1'b0;
            count_q <= '0;
        end else begin
            set_q   <= set_d;
            last_q  <= last_d;
            chg_q   <= chg_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        set_d   = set_q;
        last_d  = last_q;
        chg_d   = 1'b0;
        count_d = count_q;
        n_cnt   = '0;
        if (!enable) begin
            set_d   = CLS_NONE;
            last_d  = CLS_NONE;
            count_d = '0;
            chg_d   = (set_q != CLS_NONE);
        end else if (cand_valid) begin
            last_d = cand;
            if (cand == set_q) begin
                count_d = '0;
            end else begin
                // count stays below DEB_COUNT between samples, so +1 cannot overflow CW
                n_cnt = (cand == last_q) ? count_q + 1'b1 : CW'(1);
                if (n_cnt == DEB_W) begin
                    set_d   = cand;
                    chg_d   = 1'b1;
                    count_d = '0;
                end else begin
                    count_d = n_cnt;
                end
            end
        end
    end

    assign set        = set_q;
    assign set_change = chg_q;

endmodule

// File: rtl/tilt_classifier.sv
// rtl/tilt_classifier.sv - X/Y tilt to F/L/S/R/B classifier with hysteresis and debounce
module tilt_classifier
    import tilt_pkg::*;
#(
    parameter int DATA_W    = 12,
    parameter int TH_HI     = 400,
    parameter int TH_LO     = 300,
    parameter int DEB_COUNT = 4
) (
    input  logic                     clk,
    input  logic                     I_rst,
    input  logic                     enable,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] ax,
    input  logic signed [DATA_W-1:0] ay,
    output logic [4:0]               set,
    output logic                     set_change
);

    localparam int MW = DATA_W - 1;
    localparam logic [DATA_W-1:0] TH_HI_W = DATA_W'(TH_HI);
    localparam logic [DATA_W-1:0] TH_LO_W = DATA_W'(TH_LO);

    // The most negative sample clamps to the largest positive magnitude.
    function automatic logic [MW-1:0] sat_abs(input logic signed [DATA_W-1:0] v);
        logic [DATA_W-1:0] neg;
        neg = -v;
        if (!v[DATA_W-1]) begin
            return v[MW-1:0];
        end
        if (v == {1'b1, {MW{1'b0}}}) begin
            return {MW{1'b1}};
        end
        return neg[MW-1:0];
    endfunction

    logic [MW-1:0] mag_x_q, mag_x_d;
    logic [MW-1:0] mag_y_q, mag_y_d;
    logic          neg_x_q, neg_x_d;
    logic          neg_y_q, neg_y_d;
    logic          v1_q, v1_d;

    always_ff @(posedge clk or posedge I_rst) begin
        if (I_rst) begin
            mag_x_q <= '0;
            mag_y_q <= '0;
            neg_x_q <= 1'b0;
            neg_y_q <= 1'b0;
            v1_q    <= 1'b0;
        end else begin
            mag_x_q <= mag_x_d;
            mag_y_q <= mag_y_d;
            neg_x_q <= neg_x_d;
            neg_y_q <= neg_y_d;
            v1_q    <= v1_d;
        end
    end

    always_comb begin
        mag_x_d = mag_x_q;
        mag_y_d = mag_y_q;
        neg_x_d = neg_x_q;
        neg_y_d = neg_y_q;
        v1_d    = 1'b0;
        if (enable && sample_valid) begin
            mag_x_d = sat_abs(ax);
            mag_y_d = sat_abs(ay);
            neg_x_d = ax[DATA_W-1];
            neg_y_d = ay[DATA_W-1];
            v1_d    = 1'b1;
        end
    end

    cls_t              cls_x, cls_y, cand;
    cls_t              set_w;
    logic [DATA_W-1:0] th_x, th_y;
    logic              qx, qy;

    // Hysteresis: an axis already holding its class only needs the lower threshold.
    always_comb begin
        cls_x = axis_cls(1'b0, neg_x_q);
        cls_y = axis_cls(1'b1, neg_y_q);
        th_x  = (set_w == cls_x) ? TH_LO_W : TH_HI_W;
        th_y  = (set_w == cls_y) ? TH_LO_W : TH_HI_W;
        qx    = {1'b0, mag_x_q} >= th_x;
        qy    = {1'b0, mag_y_q} >= th_y;
        cand  = CLS_S;
        if (qy && (!qx || mag_y_q >= mag_x_q)) begin
            cand = cls_y;
        end else if (qx) begin
            cand = cls_x;
        end
    end

    tilt_debounce #(
        .DEB_COUNT(DEB_COUNT)
    ) u_debounce (
        .clk       (clk),
        .I_rst     (I_rst),
        .enable    (enable),
        .cand      (cand),
        .cand_valid(v1_q),
        .set       (set_w),
        .set_change(set_change)
    );

    assign set = set_w;

endmodule

// File: tb/tb_tilt_classifier.sv
// tb/tb_tilt_classifier.sv - randomized and directed checks of tilt_classifier against a reference model
module tb_tilt_classifier;
    import tilt_pkg::*;

    localparam int DW     = 12;
    localparam int TH_HI  = 400;
    localparam int TH_LO  = 300;
    localparam int DEB    = 4;
    localparam int MAXMAG = (1 << (DW - 1)) - 1;

    logic                 clk = 1'b0;
    logic                 I_rst = 1'b1;
    logic                 enable = 1'b0;
    logic                 sample_valid = 1'b0;
    logic signed [DW-1:0] ax = '0;
    logic signed [DW-1:0] ay = '0;
    logic [4:0]           set;
    logic                 set_change;

    int total = 0;
    int bad   = 0;

    int m_set, m_chg, m_cnt, m_last;
    bit p_v;
    int p_x, p_y;

    tilt_classifier #(
        .DATA_W(DW), .TH_HI(TH_HI), .TH_LO(TH_LO), .DEB_COUNT(DEB)
    ) dut (
        .clk(clk), .I_rst(I_rst), .enable(enable), .sample_valid(sample_valid),
        .ax(ax), .ay(ay), .set(set), .set_change(set_change)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat_mag(input int v);
        int m;
        m = (v < 0) ? -v : v;
        return (m > MAXMAG) ? MAXMAG : m;
    endfunction

    function automatic int model_cand(input int x, input int y, input int s);
        int mx, my, cx, cy, thx, thy;
        bit qx, qy;
        mx  = sat_mag(x);
        my  = sat_mag(y);
        cy  = (y >= 0) ? int'(CLS_F) : int'(CLS_B);
        cx  = (x >= 0) ? int'(CLS_R) : int'(CLS_L);
        thx = (s == cx) ? TH_LO : TH_HI;
        thy = (s == cy) ? TH_LO : TH_HI;
        qx  = mx >= thx;
        qy  = my >= thy;
        if (qx && qy) return (my >= mx) ? cy : cx;
        if (qy) return cy;
        if (qx) return cx;
        return int'(CLS_S);
    endfunction

    task automatic model_reset();
        m_set = 0; m_chg = 0; m_cnt = 0; m_last = 0; p_v = 0; p_x = 0; p_y = 0;
    endtask

    task automatic model_edge(input bit en, input bit sv, input int x, input int y);
        int c, n;
        if (!en) begin
            m_chg = (m_set != 0);
            m_set = 0; m_cnt = 0; m_last = 0; p_v = 0;
            return;
        end
        m_chg = 0;
        if (p_v) begin
            c = model_cand(p_x, p_y, m_set);
            if (c == m_set) begin
                m_cnt = 0;
            end else begin
                n = (c == m_last) ? m_cnt + 1 : 1;
                if (n == DEB) begin
                    m_set = c; m_chg = 1; m_cnt = 0;
                end else begin
                    m_cnt = n;
                end
            end
            m_last = c;
        end
        p_v = sv; p_x = x; p_y = y;
    endtask

    task automatic drive(input bit en, input bit sv, input int x, input int y);
        enable       = en;
        sample_valid = sv;
        ax           = DW'(x);
        ay           = DW'(y);
        @(posedge clk);
        model_edge(en, sv, x, y);
        #1;
        check("set", set, m_set);
        check("chg", set_change, m_chg);
        check("onehot", ($countones(set) <= 1), 1);
    endtask

    task automatic samp(input int x, input int y, input int n);
        for (int i = 0; i < n; i++) drive(1, 1, x, y);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0);
    endtask

    initial begin
        int x, y, run;
        bit en, sv;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_set", set, CLS_NONE);
        check("rst_chg", set_change, 0);
        I_rst = 1'b0;

        // basic commit
        samp(0, 500, 3);
        check("t1_pre", set, CLS_NONE);
        samp(0, 500, 1);
        check("t1_edge1", set, CLS_NONE);
        idle(1);
        check("t1_set", set, CLS_F);
        check("t1_pulse", set_change, 1);
        idle(1);
        check("t1_pulse_end", set_change, 0);

        // hysteresis
        samp(0, 350, 8); idle(1);
        check("t2_hold_f", set, CLS_F);
        samp(0, 250, 4); idle(1);
        check("t2_to_s", set, CLS_S);
        samp(0, 350, 4); idle(1);
        check("t2_stay_s", set, CLS_S);

        // priority and tie
        samp(-600, 500, 4); idle(1);
        check("t3_l", set, CLS_L);
        samp(500, -500, 4); idle(1);
        check("t3_tie_b", set, CLS_B);

        // saturation
        samp(0, 0, 4); idle(1);
        check("t4_s", set, CLS_S);
        samp(0, -2048, 4); idle(1);
        check("t4_sat_b", set, CLS_B);

        // interrupted debounce with gaps
        samp(0, 0, 4); idle(1);
        samp(600, 0, 1); idle(10);
        samp(600, 0, 2);
        samp(0, 0, 1);
        samp(600, 0, 1); idle(10);
        samp(600, 0, 1); idle(10);
        samp(600, 0, 1); idle(3);
        check("t5_hold", set, CLS_S);
        samp(600, 0, 1); idle(1);
        check("t5_r", set, CLS_R);

        // enable drop with a sample in flight
        samp(0, 500, 4); idle(1);
        check("t6_f", set, CLS_F);
        samp(0, -600, 1);
        drive(0, 0, 0, 0);
        check("t6_off", set, CLS_NONE);
        check("t6_off_chg", set_change, 1);
        drive(0, 1, 0, -600);
        check("t6_off_chg2", set_change, 0);
        idle(3);
        check("t6_dropped", set, CLS_NONE);

        // asynchronous reset between edges
        samp(0, 500, 4); idle(1);
        check("t6_f2", set, CLS_F);
        samp(0, 500, 2);
        #2 I_rst = 1'b1;
        #1;
        check("arst_set", set, CLS_NONE);
        check("arst_chg", set_change, 0);
        model_reset();
        #1 I_rst = 1'b0;
        idle(3);
        check("arst_after", set, CLS_NONE);

        // randomized runs of repeated samples
        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 3))
                0: begin x = int'($urandom_range(0, 4095)) - 2048; y = int'($urandom_range(0, 4095)) - 2048; end
                1: begin x = int'($urandom_range(250, 450)); y = int'($urandom_range(250, 450));
                         if ($urandom_range(0, 1) != 0) x = -x;
                         if ($urandom_range(0, 1) != 0) y = -y; end
                2: begin x = int'($urandom_range(0, 200)) - 100; y = int'($urandom_range(0, 200)) - 100; end
                default: begin x = ($urandom_range(0, 1) != 0) ? -2048 : 2047;
                               y = ($urandom_range(0, 1) != 0) ? -2048 : int'($urandom_range(0, 2047)); end
            endcase
            run = int'($urandom_range(1, 6));
            for (int r = 0; r < run; r++) begin
                en = ($urandom_range(0, 39) != 0);
                sv = ($urandom_range(0, 9) < 7);
                drive(en, sv, x, y);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tilt_classifier.md
Name: tilt_classifier

Overview:
- Front end for the triaxial run-state selector.
- Consumes signed X/Y accelerometer samples and classifies each one as Forward, Left, Stop, Right or Back. Thresholds carry hysteresis.
- A class is committed only after it persists for a set number of consecutive samples.
- Drives the one-hot set[4:0] request vector that the run-state selector decodes: set[0]=B, set[1]=R, set[2]=S, set[3]=L, set[4]=F.

Parameters:
- DATA_W, 12, width of the signed ax/ay samples.
- TH_HI, 400, magnitude needed to enter a tilt class.
- TH_LO, 300, magnitude needed to stay in the current tilt class. Must satisfy TH_LO <= TH_HI.
- DEB_COUNT, 4, consecutive identical candidates required to commit. Must be >= 1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- I_rst  input  1  asynchronous, active-high reset.
- enable  input  1  high = classify. Low = hold set at 0 and flush.
- sample_valid  input  1  qualifies ax/ay for one cycle.
- ax  input  DATA_W  signed X tilt; positive = right.
- ay  input  DATA_W  signed Y tilt; positive = forward.
- set  output  5  committed class, one-hot, or 0 = none.
- set_change  output  1  one-cycle pulse in the cycle set takes a new value.

Behaviour:
- Reset (asynchronous; also applies mid-operation):
  - set=0, set_change=0.
  - Debounce count=0, last candidate=0, stage-1 valid=0.
- Stage 1, at the edge where sample_valid=1 and enable=1:
  - Register |ax|, |ay|, both sign bits, and v1=1.
  - Absolute value saturates: -2^(DATA_W-1) maps to 2^(DATA_W-1)-1.
  - v1=0 otherwise.
- Stage 2, at the edge after v1=1, compute the candidate:
  - Threshold per direction: TH_LO if set currently equals that direction's class, else TH_HI.
  - qy = |ay| >= th_y; qx = |ax| >= th_x.
  - Both qualify: the larger magnitude wins; an equal magnitude goes to Y.
  - Y wins: F if ay >= 0, else B. X wins: R if ax >= 0, else L.
  - Neither qualifies: S.
- Debounce, applied in the same stage-2 update:
  - cand == set: count<=0 and last<=cand.
  - Otherwise: if cand == last, n=count+1; else n=1 and last<=cand.
  - If n == DEB_COUNT: set<=cand, set_change<=1, count<=0.
  - Else count<=n.
- Latency: with sample k qualified at edge E, the commit caused by sample k is visible after edge E+1.
- Throughput: back-to-back samples on every cycle are supported. Gaps between samples do not reset the count; only a differing candidate does.
- set_change=1 only in the cycle following a commit edge. A commit to a value equal to set cannot occur.
- enable=0, synchronous:
  - set<=0, count<=0, last<=0, v1<=0. A sample in flight is dropped.
  - set_change<=1 if set was non-zero, else 0.
  - Samples arriving while enable=0 are ignored.
- Counter width: clog2(DEB_COUNT+1). The count never exceeds DEB_COUNT-1 between samples.
- Invariant: set is always 0 or exactly one-hot.

Decomposition:
- Shared package tilt_pkg holds:
  - Class localparams: CLS_NONE=5'b00000, CLS_B=5'b00001, CLS_R=5'b00010, CLS_S=5'b00100, CLS_L=5'b01000, CLS_F=5'b10000.
  - These same codes are used by the triaxial run-state selector.
- One sub-module, tilt_debounce:
  - Inputs: cand, cand_valid, enable.
  - Outputs: set, set_change.
  - Parameterised by DEB_COUNT.
  - Holds the count and last-candidate registers.
- tilt_classifier holds the abs/saturate stage and the threshold/priority logic.

Test Plan (defaults: TH_HI=400, TH_LO=300, DEB_COUNT=4):
1. Basic commit:
   - After reset, enable=1; 3 samples ay=500, ax=0 on consecutive cycles -> set stays 00000.
   - 4th sample -> set=10000 and set_change=1 for exactly one cycle, 2 edges after the 4th sample.
2. Hysteresis:
   - From set=F: 8 samples ay=350 -> set stays 10000.
   - Then 4 samples ay=250 -> set=00100 (S).
   - From S: 4 samples ay=350 -> stays S.
3. Priority and tie:
   - ax=-600, ay=500 ×4 -> set=01000 (L).
   - Then ax=500, ay=-500 ×4 -> set=00001 (B); the tie goes to Y.
4. Saturation: ay=-2048, ax=0 ×4 -> set=00001, with no wrap to a positive value.
5. Interrupted debounce:
   - From S: R,R,R,S,R,R,R (ax=600 for R) -> no change.
   - One further R -> set=00010.
   - Sample gaps of 10 idle cycles inside the run do not reset the count.
6. Control events:
   - enable dropped while set=F with a sample in flight -> set=00000 with a set_change pulse; the in-flight sample has no effect.
   - I_rst pulsed asynchronously mid-run, between clock edges -> set=00000 immediately.
